// File: rtl/button_if.sv
// Button signal bundle: the raw button input plus the conditioned level and event strobes.
interface button_if;
  logic btn;
  logic level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;

  modport master (
    output btn,
    input  level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  btn,
    output level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw button, then emits press/release/long-press strobes.
// Define BUTTON_COND_REPEAT_EN to add periodic auto-repeat strobes while a long press is held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int LONG_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic     clk,
  input  logic     reset,
  button_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      LONG_CYCLES < 1 || LONG_CYCLES > 1048575 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_param_check
    $error("button_conditioner: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] HOLD_LAST = 20'(LONG_CYCLES);

  state_t      state;
  logic        sync1;
  logic        btn_s;
  logic [15:0] db_cnt;
  logic        level_q;
  logic [19:0] hold_cnt;
  logic        press_q;
  logic        release_q;
  logic        long_q;

  logic        accept;
  logic        accept_rise;
  logic        accept_fall;

  // A level change is accepted on the edge where the mismatch has persisted DEBOUNCE_CYCLES samples.
  assign accept      = (btn_s != level_q) && (db_cnt == DB_LAST);
  assign accept_rise = accept && !level_q;
  assign accept_fall = accept && level_q;

`ifdef BUTTON_COND_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES);

  logic [15:0] rep_cnt;
  logic        repeat_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      btn_s     <= 1'b0;
      db_cnt    <= '0;
      level_q   <= 1'b0;
      hold_cnt  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
`ifdef BUTTON_COND_REPEAT_EN
      rep_cnt   <= '0;
      repeat_q  <= 1'b0;
`endif
    end else begin
      sync1 <= bus.btn;
      btn_s <= sync1;

      if (btn_s == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt  <= '0;
        level_q <= !level_q;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end

      press_q   <= accept_rise;
      release_q <= accept_fall;
      long_q    <= 1'b0;
`ifdef BUTTON_COND_REPEAT_EN
      repeat_q  <= 1'b0;
`endif

      // Release is checked first in HELD and LONG so it beats a coincident long or repeat event.
      unique case (state)
        IDLE: begin
          if (accept_rise) begin
            state    <= HELD;
            hold_cnt <= 20'd1;
          end
        end
        HELD: begin
          if (accept_fall) begin
            state <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            state  <= LONG;
            long_q <= 1'b1;
`ifdef BUTTON_COND_REPEAT_EN
            rep_cnt <= 16'd1;
`endif
          end else begin
            hold_cnt <= hold_cnt + 20'd1;
          end
        end
        LONG: begin
          if (accept_fall) begin
            state <= IDLE;
`ifdef BUTTON_COND_REPEAT_EN
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt  <= 16'd1;
            repeat_q <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.level         = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
`ifdef BUTTON_COND_REPEAT_EN
  assign bus.repeat_pulse  = repeat_q;
`else
  assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a default instance driven from a vector table,
// plus a DEBOUNCE_CYCLES=1/LONG_CYCLES=1 instance exercised by hand-written sequences.
module tb_button_conditioner;

`ifdef BUTTON_COND_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  typedef struct {
    logic btn;
    int   cycles;
    int   lvl;
    int   p;
    int   r;
    int   lg;
    int   rep;
    int   np;
    int   nr;
    int   nl;
    int   nrep;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cnt_p[2];
  int   cnt_r[2];
  int   cnt_l[2];
  int   cnt_rep[2];
  vec_t vecs[$];

  button_if bus0 ();
  button_if bus1 ();

  button_conditioner dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (1),
    .LONG_CYCLES     (1),
    .REPEAT_CYCLES   (16)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = !clk;
  end

  function automatic vec_t mk(input logic btn, input int cycles, input int lvl, input int p,
                              input int r, input int lg, input int rep, input int np,
                              input int nr, input int nl, input int nrep);
    vec_t v;
    v.btn = btn; v.cycles = cycles; v.lvl = lvl; v.p = p; v.r = r; v.lg = lg; v.rep = rep;
    v.np = np; v.nr = nr; v.nl = nl; v.nrep = nrep;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drives both buttons, then steps n clocks, tallying strobes of each instance every cycle.
  task automatic applyStimulus(input logic b0, input logic b1, input int n);
    bus0.btn = b0;
    bus1.btn = b1;
    for (int d = 0; d < 2; d++) begin
      cnt_p[d] = 0; cnt_r[d] = 0; cnt_l[d] = 0; cnt_rep[d] = 0;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cnt_p[0]   += int'(bus0.press_pulse);
      cnt_r[0]   += int'(bus0.release_pulse);
      cnt_l[0]   += int'(bus0.long_pulse);
      cnt_rep[0] += int'(bus0.repeat_pulse);
      cnt_p[1]   += int'(bus1.press_pulse);
      cnt_r[1]   += int'(bus1.release_pulse);
      cnt_l[1]   += int'(bus1.long_pulse);
      cnt_rep[1] += int'(bus1.repeat_pulse);
    end
  endtask

  task automatic checkOutput(input int d, input string name, input vec_t v);
    int lv, p, r, lg, rp;
    if (d == 0) begin
      lv = int'(bus0.level); p = int'(bus0.press_pulse); r = int'(bus0.release_pulse);
      lg = int'(bus0.long_pulse); rp = int'(bus0.repeat_pulse);
    end else begin
      lv = int'(bus1.level); p = int'(bus1.press_pulse); r = int'(bus1.release_pulse);
      lg = int'(bus1.long_pulse); rp = int'(bus1.repeat_pulse);
    end
    chk({name, ".level"}, lv, v.lvl);
    chk({name, ".press"}, p, v.p);
    chk({name, ".release"}, r, v.r);
    chk({name, ".long"}, lg, v.lg);
    chk({name, ".repeat"}, rp, v.rep);
    chk({name, ".n_press"}, cnt_p[d], v.np);
    chk({name, ".n_release"}, cnt_r[d], v.nr);
    chk({name, ".n_long"}, cnt_l[d], v.nl);
    chk({name, ".n_repeat"}, cnt_rep[d], v.nrep);
  endtask

  task automatic checkIdle(input string name);
    chk({name, ".dut0.level"}, int'(bus0.level), 0);
    chk({name, ".dut0.press"}, int'(bus0.press_pulse), 0);
    chk({name, ".dut0.release"}, int'(bus0.release_pulse), 0);
    chk({name, ".dut0.long"}, int'(bus0.long_pulse), 0);
    chk({name, ".dut0.repeat"}, int'(bus0.repeat_pulse), 0);
    chk({name, ".dut1.level"}, int'(bus1.level), 0);
    chk({name, ".dut1.press"}, int'(bus1.press_pulse), 0);
    chk({name, ".dut1.release"}, int'(bus1.release_pulse), 0);
  endtask

  task automatic step(input int d, input string name, input vec_t v);
    if (d == 0) applyStimulus(v.btn, 1'b0, v.cycles);
    else        applyStimulus(1'b0, v.btn, v.cycles);
    checkOutput(d, name, v);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Clean press held 40 cycles, then release.
    vecs.push_back(mk(1, 9,   0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1,   1, 1, 0, 0, 0,   1, 0, 0, 0));
    vecs.push_back(mk(1, 1,   1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 29,  1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 9,   1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1,   0, 0, 1, 0, 0,   0, 1, 0, 0));
    vecs.push_back(mk(0, 5,   0, 0, 0, 0, 0,   0, 0, 0, 0));
    // Bounce every 3 cycles for 30 cycles, then low.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(logic'(i % 2 == 0), 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 12,  0, 0, 0, 0, 0,   0, 0, 0, 0));
    // 200-cycle hold: long at 74, repeats at 90, 106, ... when enabled.
    vecs.push_back(mk(1, 10,  1, 1, 0, 0, 0,   1, 0, 0, 0));
    vecs.push_back(mk(1, 63,  1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1,   1, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 15,  1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1,   1, 0, 0, 0, REP, 0, 0, 0, REP));
    vecs.push_back(mk(1, 110, 1, 0, 0, 0, 0,   0, 0, 0, 6 * REP));
    vecs.push_back(mk(0, 9,   1, 0, 0, 0, 0,   0, 0, 0, REP));
    vecs.push_back(mk(0, 1,   0, 0, 1, 0, 0,   0, 1, 0, 0));
    vecs.push_back(mk(0, 20,  0, 0, 0, 0, 0,   0, 0, 0, 0));
    // Release accepted on the very cycle the hold would reach LONG_CYCLES.
    vecs.push_back(mk(1, 10,  1, 1, 0, 0, 0,   1, 0, 0, 0));
    vecs.push_back(mk(1, 54,  1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 9,   1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1,   0, 0, 1, 0, 0,   0, 1, 0, 0));
    vecs.push_back(mk(0, 5,   0, 0, 0, 0, 0,   0, 0, 0, 0));
    // Release coincident with the first repeat slot.
    vecs.push_back(mk(1, 10,  1, 1, 0, 0, 0,   1, 0, 0, 0));
    vecs.push_back(mk(1, 63,  1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1,   1, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 6,   1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 9,   1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1,   0, 0, 1, 0, 0,   0, 1, 0, 0));
    vecs.push_back(mk(0, 20,  0, 0, 0, 0, 0,   0, 0, 0, 0));

    reset    = 1'b1;
    bus0.btn = 1'b0;
    bus1.btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 3);

    for (int i = 0; i < vecs.size(); i++)
      step(0, $sformatf("vec%0d", i), vecs[i]);

    // Reset asserted mid-press aborts it silently; a still-held button is a fresh press.
    step(0, "rst_hold", mk(1, 49, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    reset = 1'b1;
    #1;
    checkIdle("rst_now");
    step(0, "rst_in", mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    step(0, "rst_wait", mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, "rst_press", mk(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    step(0, "rst_relw", mk(0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, "rst_rel", mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    step(0, "rst_idle", mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Minimum debounce and hold lengths on the second instance.
    step(1, "min_wait", mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, "min_press", mk(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    step(1, "min_long", mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0));
    step(1, "min_held", mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, "min_relw", mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, "min_rel", mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    step(1, "min_idle", mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 8: consecutive stable synchronized samples required to accept a level change (legal range 1..65535).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 64: cycles of accepted-high level before a long-press event (legal range 1..2^20-1).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 16: auto-repeat period once a long press is recognized (legal range 1..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port btn, input, 1 bit: raw button, asynchronous to clk, active-high, may bounce.
REQ-007 The block SHALL have port level, output, 1 bit: debounced button state.
REQ-008 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on accepted press.
REQ-009 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on accepted release.
REQ-010 The block SHALL have port long_pulse, output, 1 bit: one-cycle strobe when the hold reaches LONG_CYCLES.
REQ-011 The block SHALL have port repeat_pulse, output, 1 bit: one-cycle strobe per auto-repeat period.
REQ-012 All outputs SHALL be driven directly from flops.

Function
REQ-013 btn SHALL pass through a 2-flop synchronizer; its output is btn_s.
REQ-014 A debounce counter SHALL increment each cycle btn_s != level and clear to 0 on any cycle btn_s == level.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 while btn_s != level, then on the next edge level SHALL toggle and the counter SHALL clear.
REQ-016 Consequently, press latency from the first clk edge sampling btn=1 to level=1 SHALL be exactly 2+DEBOUNCE_CYCLES cycles for clean input; release latency SHALL be identical.
REQ-017 press_pulse SHALL assert in the same cycle level first reads 1, for exactly one cycle; release_pulse SHALL do the same on level 1->0.
REQ-018 The FSM SHALL have states IDLE (level=0), HELD (level=1, hold<LONG_CYCLES) and LONG (long press recognized).
REQ-019 FSM transitions: IDLE->HELD on accepted press; HELD->LONG when the hold counter reaches LONG_CYCLES; HELD or LONG->IDLE on accepted release.
REQ-020 The hold counter (20 bits) SHALL clear on entering HELD and increment each cycle in HELD; level is counted as cycle 1.
REQ-021 long_pulse SHALL assert for one cycle on the HELD->LONG transition, i.e. exactly LONG_CYCLES cycles after press_pulse.
REQ-022 A release accepted in the same cycle the hold counter would reach LONG_CYCLES SHALL win: go to IDLE, release_pulse=1, long_pulse=0.
REQ-023 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no pulses and no state change.
REQ-024 At most one of press_pulse and release_pulse SHALL be high in any cycle.

Reset
REQ-025 Asserting reset SHALL immediately clear synchronizer flops, debounce counter, hold and repeat counters, FSM (IDLE), level and all pulses to 0.
REQ-026 Reset SHALL take effect even mid-press; the block SHALL emit no release_pulse for a press aborted by reset.
REQ-027 After reset deassertion, a btn held at 1 SHALL be treated as a new press (press_pulse after 2+DEBOUNCE_CYCLES cycles).

Configuration
REQ-028 With macro BUTTON_COND_REPEAT_EN defined, a repeat counter SHALL clear on entering LONG, and repeat_pulse SHALL assert for one cycle every REPEAT_CYCLES cycles while in LONG, the first at REPEAT_CYCLES cycles after long_pulse.
REQ-029 Without BUTTON_COND_REPEAT_EN, the repeat counter SHALL be absent, repeat_pulse SHALL be tied to 0, and LONG SHALL hold until release.
REQ-030 Release SHALL suppress a coincident repeat_pulse.

Verification
REQ-031 Scenario: clean press of btn=1 for 40 cycles with defaults -> level and press_pulse at cycle 10; release_pulse 10 cycles after btn falls; no long_pulse.
REQ-032 Scenario: btn bouncing 1/0 every 3 cycles for 30 cycles, then low -> no pulses, level stays 0.
REQ-033 Scenario: btn held 200 cycles, BUTTON_COND_REPEAT_EN defined -> press_pulse at cycle 10, long_pulse at 74, repeat_pulse at 90, 106, 122...; one release_pulse.
REQ-034 Scenario: same stimulus without the macro -> long_pulse at 74, repeat_pulse never asserted.
REQ-035 Scenario: reset asserted at cycle 50 of a 200-cycle hold, released at cycle 55 -> all outputs 0 immediately, press_pulse again at cycle 65, no release_pulse from the aborted press.
REQ-036 Scenario: DEBOUNCE_CYCLES=1 and LONG_CYCLES=1 -> press_pulse 3 cycles after btn rise, long_pulse on the following cycle.
